// File: rtl/ahbl_to_apb.sv
// AHB-lite slave to APB3 master bridge: one APB SETUP/ACCESS sequence per accepted AHB transfer.
// Define AHBL_APB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYCLES with an AHB error.
module ahbl_to_apb #(
    parameter int W_HADDR        = 32,
    parameter int W_PADDR        = 16,
    parameter int W_DATA         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               src_hready,
    output logic               src_hready_resp,
    output logic               src_hresp,
    input  logic [W_HADDR-1:0] src_haddr,
    input  logic               src_hwrite,
    input  logic [1:0]         src_htrans,
    input  logic [2:0]         src_hsize,
    input  logic [W_DATA-1:0]  src_hwdata,
    output logic [W_DATA-1:0]  src_hrdata,
    output logic               apb_psel,
    output logic               apb_penable,
    output logic               apb_pwrite,
    output logic [W_PADDR-1:0] apb_paddr,
    output logic [W_DATA-1:0]  apb_pwdata,
    input  logic [W_DATA-1:0]  apb_prdata,
    input  logic               apb_pready,
    input  logic               apb_pslverr
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
    } state_t;

    state_t state, state_nxt;
    logic   can_accept;
    logic   accept;
    logic   to_hit;

    // Every access is full width and only the low address bits reach APB.
    logic unused_inputs;
    assign unused_inputs = ^{src_hsize, src_haddr[W_HADDR-1:W_PADDR], src_htrans[0]};

    assign can_accept = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR2);
    assign accept     = can_accept && src_hready && src_htrans[1];

`ifdef AHBL_APB_TIMEOUT_EN
    localparam int W_CNT = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [W_CNT-1:0] to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt <= '0;
        else if (state == S_SETUP)
            to_cnt <= '0;
        else if (state == S_ACCESS && !apb_pready)
            to_cnt <= to_cnt + 1'b1;
    end

    // The stalled cycle that brings the count to the limit is the last ACCESS cycle.
    assign to_hit = (to_cnt == W_CNT'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign to_hit             = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR2: begin
                if (src_hready)
                    state_nxt = accept ? S_SETUP : S_IDLE;
            end
            S_SETUP:  state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (apb_pready)
                    state_nxt = apb_pslverr ? S_ERR1 : S_DONE;
                else if (to_hit)
                    state_nxt = S_ERR1;
            end
            S_ERR1:   state_nxt = S_ERR2;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs come straight from flops so pready/pslverr never reach hready_resp combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            apb_psel        <= 1'b0;
            apb_penable     <= 1'b0;
            src_hready_resp <= 1'b1;
            src_hresp       <= 1'b0;
        end else begin
            apb_psel        <= (state_nxt == S_SETUP) || (state_nxt == S_ACCESS);
            apb_penable     <= (state_nxt == S_ACCESS);
            src_hready_resp <= !((state_nxt == S_SETUP) || (state_nxt == S_ACCESS) ||
                                 (state_nxt == S_ERR1));
            src_hresp       <= (state_nxt == S_ERR1) || (state_nxt == S_ERR2);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            apb_paddr  <= '0;
            apb_pwrite <= 1'b0;
            apb_pwdata <= '0;
            src_hrdata <= '0;
        end else begin
            if (accept) begin
                apb_paddr  <= src_haddr[W_PADDR-1:0];
                apb_pwrite <= src_hwrite;
            end
            // SETUP is the AHB data phase, so hwdata is valid here.
            if (state == S_SETUP)
                apb_pwdata <= src_hwdata;
            if (state == S_ACCESS && apb_pready && !apb_pslverr && !apb_pwrite)
                src_hrdata <= apb_prdata;
        end
    end

endmodule

// File: tb/tb_ahbl_to_apb.sv
// Bench for ahbl_to_apb: directed table, random pipelined traffic against a transfer-level model,
// reset mid-ACCESS, and ACCESS timeout / no-timeout behaviour.
module tb_ahbl_to_apb;

    localparam int TO = 4;
`ifdef AHBL_APB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        int          waits;
        logic        err;
        logic [31:0] rdata;
        int          idle;
    } req_t;

    typedef struct {
        int          len;
        int          errw;
        logic        hresp;
        logic [31:0] hrdata;
    } obs_t;

    typedef struct {
        req_t        rq;
        int          len;
        logic        hresp;
        logic [31:0] hrdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hr_block;
    logic        hready_bus;
    logic        src_hready_resp, src_hresp, src_hwrite;
    logic [31:0] src_haddr, src_hwdata, src_hrdata;
    logic [1:0]  src_htrans;
    logic [2:0]  src_hsize;
    logic        apb_psel, apb_penable, apb_pwrite, apb_pready, apb_pslverr;
    logic [15:0] apb_paddr;
    logic [31:0] apb_pwdata, apb_prdata;

    assign hready_bus = src_hready_resp && !hr_block;
    always #5 clk = ~clk;

    ahbl_to_apb #(.W_HADDR(32), .W_PADDR(16), .W_DATA(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .src_hready(hready_bus), .src_hready_resp(src_hready_resp), .src_hresp(src_hresp),
        .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
        .src_hsize(src_hsize), .src_hwdata(src_hwdata), .src_hrdata(src_hrdata),
        .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
        .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata),
        .apb_pready(apb_pready), .apb_pslverr(apb_pslverr)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic req_t mk(logic [31:0] a, logic w, logic [31:0] wd, int ws, logic e,
                                logic [31:0] rd, int idl);
        req_t r;
        r.addr = a; r.write = w; r.wdata = wd; r.waits = ws; r.err = e; r.rdata = rd; r.idle = idl;
        return r;
    endfunction

    function automatic bit times_out(req_t r);
        return TO_EN && (r.waits >= TO);
    endfunction

    // ---------------- AHB master: pipelined, presents next address during wait states
    req_t ahb_q[$];
    req_t slv_q[$];
    obs_t obs_q[$];
    req_t dp, nxt;
    logic dp_valid, nxt_valid, rand_blk;
    int   dp_cnt, dp_errw, idle_cnt;

    task automatic master_reset();
        dp_valid = 1'b0; nxt_valid = 1'b0; idle_cnt = 0; hr_block = 1'b0;
        src_htrans = 2'b00;
    endtask

    task automatic master_step();
        logic hb;
        logic idle_now;
        obs_t o;
        if (nxt_valid) begin
            dp = nxt; dp_valid = 1'b1; dp_cnt = 0; dp_errw = 0; nxt_valid = 1'b0;
        end
        idle_now   = !dp_valid;
        src_hwdata = dp_valid ? dp.wdata : $urandom;
        if (dp_valid) begin
            dp_cnt++;
            if (!src_hready_resp && src_hresp) dp_errw++;
            if (src_hready_resp) begin
                o.len = dp_cnt; o.errw = dp_errw; o.hresp = src_hresp; o.hrdata = src_hrdata;
                obs_q.push_back(o);
                dp_valid = 1'b0;
            end
        end else begin
            chk("idle_resp", {src_hready_resp, src_hresp}, 2'b10);
        end
        hr_block = rand_blk && idle_now && ($urandom_range(0, 3) == 0);
        hb       = src_hready_resp && !hr_block;
        if (ahb_q.size() != 0 && (!hb || idle_cnt >= ahb_q[0].idle)) begin
            src_htrans = 2'b10;
            src_haddr  = ahb_q[0].addr;
            src_hwrite = ahb_q[0].write;
            src_hsize  = 3'b010;
            if (hb) begin
                nxt = ahb_q.pop_front(); nxt_valid = 1'b1; idle_cnt = 0;
                slv_q.push_back(nxt);
            end
        end else begin
            src_htrans = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
            src_haddr  = $urandom;
            src_hwrite = 1'($urandom_range(0, 1));
            src_hsize  = 3'($urandom_range(0, 7));
            if (hb && ahb_q.size() != 0) idle_cnt++;
        end
    endtask

    task automatic run_master(int budget);
        int cyc;
        cyc = 0;
        while ((ahb_q.size() != 0 || dp_valid || nxt_valid) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            master_step();
        end
        if (cyc >= budget) begin
            n_chk++; n_err++;
            $display("FAIL master_budget: %0d cycles used, limit %0d", cyc, budget);
        end
    endtask

    // ---------------- APB peripheral: inserts configured wait states, checks each transfer
    req_t cur;
    logic sel_prev, s_done;
    int   acc, sel_cnt;

    always @(negedge clk) begin
        if (rst) begin
            sel_prev = 1'b0; s_done = 1'b0; slv_q.delete();
            apb_pready = 1'b0; apb_pslverr = 1'b0; apb_prdata = 32'h0;
        end else begin
            apb_pready = 1'b0; apb_pslverr = 1'b0; apb_prdata = $urandom;
            if (sel_prev && s_done) chk("psel_drop", apb_psel, 1'b0);
            if (sel_prev && !s_done && !apb_psel)
                chk("apb_abandon", {acc == TO, times_out(cur)}, 2'b11);
            if (apb_psel && !sel_prev) begin
                chk("apb_expected", slv_q.size() != 0, 1'b1);
                if (slv_q.size() != 0) cur = slv_q.pop_front();
                chk("setup_penable", apb_penable, 1'b0);
                sel_cnt = 0; acc = 0; s_done = 1'b0;
            end
            if (apb_psel && !s_done) begin
                sel_cnt++;
                if (apb_penable) begin
                    if (acc == cur.waits) begin
                        apb_pready = 1'b1; apb_pslverr = cur.err; apb_prdata = cur.rdata;
                        s_done = 1'b1;
                        chk("no_timeout_expected", times_out(cur), 1'b0);
                        chk("paddr", apb_paddr, cur.addr[15:0]);
                        chk("pwrite", apb_pwrite, cur.write);
                        if (cur.write) chk("pwdata", apb_pwdata, cur.wdata);
                        chk("psel_cycles", sel_cnt, cur.waits + 2);
                    end
                    acc++;
                end
            end
            sel_prev = apb_psel;
        end
    end

    // ---------------- stimulus
    vec_t vt[8];
    vec_t ev[$];
    logic [31:0] m_hrdata;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        obs_t o;
        vec_t e;
        req_t r;
        int   k;
        rst = 1'b1; rand_blk = 1'b0;
        src_haddr = '0; src_hwrite = 1'b0; src_hsize = '0; src_hwdata = '0;
        master_reset();
        repeat (3) @(negedge clk);
        chk("rst_psel", apb_psel, 1'b0);
        chk("rst_penable", apb_penable, 1'b0);
        chk("rst_pwrite", apb_pwrite, 1'b0);
        chk("rst_paddr", apb_paddr, 16'h0);
        chk("rst_pwdata", apb_pwdata, 32'h0);
        chk("rst_hrdata", src_hrdata, 32'h0);
        chk("rst_hready_resp", src_hready_resp, 1'b1);
        chk("rst_hresp", src_hresp, 1'b0);
        rst = 1'b0;

        // {request, data-phase length, final hresp, hrdata at end of data phase}
        vt[0] = '{mk(32'h4000_0010, 1, 32'hDEAD_BEEF, 0, 0, 32'h0, 2), 3, 1'b0, 32'h0};
        vt[1] = '{mk(32'h4000_0020, 0, 32'h0, 3, 0, 32'h1234_5678, 1), 6, 1'b0, 32'h1234_5678};
        vt[2] = '{mk(32'h4000_0030, 1, 32'h0BAD_F00D, 0, 1, 32'h0, 1), 4, 1'b1, 32'h1234_5678};
        vt[3] = '{mk(32'h0000_0004, 0, 32'h0, 0, 0, 32'hA5A5_0004, 0), 3, 1'b0, 32'hA5A5_0004};
        vt[4] = '{mk(32'h0000_0008, 1, 32'h0000_0808, 0, 0, 32'h0, 0), 3, 1'b0, 32'hA5A5_0004};
        vt[5] = '{mk(32'h8000_1234, 0, 32'h0, 1, 1, 32'hFFFF_FFFF, 0), 5, 1'b1, 32'hA5A5_0004};
`ifdef AHBL_APB_TIMEOUT_EN
        vt[6] = '{mk(32'h0000_000C, 0, 32'h0, 4, 0, 32'h0C0C_0C0C, 0), 7, 1'b1, 32'hA5A5_0004};
        vt[7] = '{mk(32'h0000_0010, 0, 32'h0, 2, 0, 32'h5A5A_0010, 3), 5, 1'b0, 32'h5A5A_0010};
`else
        vt[6] = '{mk(32'h0000_000C, 0, 32'h0, 4, 0, 32'h0C0C_0C0C, 0), 7, 1'b0, 32'h0C0C_0C0C};
        vt[7] = '{mk(32'h0000_0010, 0, 32'h0, 2, 0, 32'h5A5A_0010, 3), 5, 1'b0, 32'h5A5A_0010};
`endif
        for (int i = 0; i < 8; i++) ahb_q.push_back(vt[i].rq);
        run_master(1000);
        chk("tbl_count", obs_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (obs_q.size() == 0) break;
            o = obs_q.pop_front();
            chk($sformatf("tbl%0d_len", i), o.len, vt[i].len);
            chk($sformatf("tbl%0d_errw", i), o.errw, vt[i].hresp ? 1 : 0);
            chk($sformatf("tbl%0d_hresp", i), o.hresp, vt[i].hresp);
            chk($sformatf("tbl%0d_hrdata", i), o.hrdata, vt[i].hrdata);
        end

        // Random pipelined traffic with IDLE/BUSY gaps and bus-level hready stalls.
        m_hrdata = vt[7].hrdata;
        rand_blk = 1'b1;
        for (int i = 0; i < 60; i++) begin
            r = mk($urandom, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 5),
                   ($urandom_range(0, 4) == 0), $urandom, $urandom_range(0, 2));
            ahb_q.push_back(r);
            e.rq     = r;
            e.len    = times_out(r) ? TO + 3 : r.waits + 3 + (r.err ? 1 : 0);
            e.hresp  = times_out(r) || r.err;
            if (!r.write && !e.hresp) m_hrdata = r.rdata;
            e.hrdata = m_hrdata;
            ev.push_back(e);
        end
        run_master(5000);
        rand_blk = 1'b0;
        chk("rnd_count", obs_q.size(), ev.size());
        k = 0;
        while (obs_q.size() != 0 && ev.size() != 0) begin
            o = obs_q.pop_front();
            e = ev.pop_front();
            chk($sformatf("rnd%0d_len", k), o.len, e.len);
            chk($sformatf("rnd%0d_errw", k), o.errw, e.hresp ? 1 : 0);
            chk($sformatf("rnd%0d_hresp", k), o.hresp, e.hresp);
            chk($sformatf("rnd%0d_hrdata", k), o.hrdata, e.hrdata);
            k++;
        end

        // Reset while the APB slave is stalling in ACCESS.
        slv_q.push_back(mk(32'h4000_0044, 0, 32'h0, 50, 0, 32'h1111_2222, 0));
        @(negedge clk);
        src_htrans = 2'b10; src_haddr = 32'h4000_0044; src_hwrite = 1'b0;
        @(negedge clk);
        src_htrans = 2'b00;
        k = 0;
        while (!(apb_psel && apb_penable) && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("rst_reach_access", apb_psel && apb_penable, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_psel", apb_psel, 1'b0);
        chk("midrst_penable", apb_penable, 1'b0);
        chk("midrst_hready_resp", src_hready_resp, 1'b1);
        chk("midrst_hresp", src_hresp, 1'b0);
        chk("midrst_paddr", apb_paddr, 16'h0);
        chk("midrst_hrdata", src_hrdata, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        master_reset();
        ahb_q.push_back(mk(32'h4000_0048, 0, 32'h0, 1, 0, 32'h7777_8888, 0));
        run_master(100);
        chk("postrst_count", obs_q.size(), 1);
        if (obs_q.size() != 0) begin
            o = obs_q.pop_front();
            chk("postrst_len", o.len, 4);
            chk("postrst_hresp", o.hresp, 1'b0);
            chk("postrst_hrdata", o.hrdata, 32'h7777_8888);
        end

`ifndef AHBL_APB_TIMEOUT_EN
        // Without the timeout a silent peripheral holds the bridge in ACCESS indefinitely.
        slv_q.push_back(mk(32'h0000_0050, 0, 32'h0, 1000, 0, 32'h0, 0));
        @(negedge clk);
        src_htrans = 2'b10; src_haddr = 32'h0000_0050; src_hwrite = 1'b0;
        @(negedge clk);
        src_htrans = 2'b00;
        repeat (101) @(negedge clk);
        chk("hang_access_100", {apb_psel, apb_penable, src_hready_resp, src_hresp}, 4'b1100);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
